// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back stage register file.
//   NUM_REGS / ADDR_W : 8 architectural registers, 3-bit index
//   DATA_W            : 64-bit register width
//   CNT_W             : 32-bit retired-instruction counter
//   wb_src_e          : which M/WB field feeds the register write
// Helpers:
//   sel_src()    : fixed-priority source decode (lw > movi > addi > subi)
//   multi_flag() : true when two or more opcode flags are set together
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 64;
  localparam int CNT_W    = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_IMM  = 2'd2,
    SRC_ALU  = 2'd3
  } wb_src_e;

  // addi and subi share the ALU result, so their relative order does not
  // change the selected data; lw and movi must win over the ALU.
  function automatic wb_src_e sel_src(input logic lw, input logic movi,
                                      input logic addi, input logic subi);
    wb_src_e s;
    if (lw)                s = SRC_MEM;
    else if (movi)         s = SRC_IMM;
    else if (addi || subi) s = SRC_ALU;
    else                   s = SRC_NONE;
    return s;
  endfunction

  // Clearing the lowest set bit leaves a nonzero value only if another bit
  // was also set.
  function automatic logic multi_flag(input logic [4:0] f);
    return (f & (f - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_if
// Write-back bus between the M/WB pipeline register and the register file.
// Carries the opcode flags, write enable, candidate write data and
// destination index toward the register file, and the combinational
// write echo (wb_valid/wb_addr/wb_data) back toward the forwarding logic.
//   master : M/WB side, drives flags/data, observes the echo
//   slave  : register file side, consumes flags/data, drives the echo
// -----------------------------------------------------------------------------
interface wb_regfile_if;
  import wb_pkg::*;

  logic              noop_wb;
  logic              addi_wb;
  logic              movi_wb;
  logic              lw_wb;
  logic              sw_wb;
  logic              subi_wb;
  logic              wre_wb;
  logic [DATA_W-1:0] d_out_wb;
  logic [DATA_W-1:0] alu_result_wb;
  logic [DATA_W-1:0] offset_wb;
  logic [ADDR_W-1:0] rt_wb;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output noop_wb, addi_wb, movi_wb, lw_wb, sw_wb, subi_wb, wre_wb,
    output d_out_wb, alu_result_wb, offset_wb, rt_wb,
    input  wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  noop_wb, addi_wb, movi_wb, lw_wb, sw_wb, subi_wb, wre_wb,
    input  d_out_wb, alu_result_wb, offset_wb, rt_wb,
    output wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/regfile_8x64.sv
// -----------------------------------------------------------------------------
// regfile_8x64
// Eight 64-bit registers, one synchronous write port, two asynchronous
// read ports. Register 0 is hardwired to zero: writes to it are dropped and
// reads of it return zero.
// Ports:
//   clk, rst               : clock, synchronous active-high clear of all regs
//   i_we, i_waddr, i_wdata : write port (commits on rising clk)
//   i_raddr_a, o_rdata_a   : read port A (combinational)
//   i_raddr_b, o_rdata_b   : read port B (combinational)
// -----------------------------------------------------------------------------
module regfile_8x64
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // r_mem[0] is never written after reset, but the explicit zero keeps r0
  // correct even before the first reset.
  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Write-back stage: selects the write source from the M/WB opcode flags,
// writes the register file, echoes the write for forwarding, counts retired
// instructions and flags illegal multi-opcode words.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   wb (slave)           : M/WB flags/data in, write echo out
//   rd_addr_a/b          : decode-stage read indices
//   rd_data_a/b          : read data (combinational)
//   retire_cnt           : saturating count of retired instructions
//   flag_err             : sticky, set when two or more opcode flags coincide
// Configuration:
//   WB_BYPASS_EN : when defined, a read hitting the register being written
//                  this cycle returns the new data; otherwise it returns the
//                  stored value until the edge.
// -----------------------------------------------------------------------------
module wb_regfile
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  wb_regfile_if.slave       wb,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              flag_err
);

  wb_src_e           w_src;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_wen;
  logic [4:0]        w_ops;
  logic              w_retire;
  logic              w_multi;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_unused_noop;

  logic [CNT_W-1:0]  r_retire_cnt;
  logic              r_flag_err;

  // noop carries no action of its own: with other flags set those flags
  // govern, and alone it neither writes nor retires.
  assign w_unused_noop = wb.noop_wb;

  assign w_src = sel_src(wb.lw_wb, wb.movi_wb, wb.addi_wb, wb.subi_wb);

  always_comb begin
    w_sel_data = '0;
    case (w_src)
      SRC_MEM: w_sel_data = wb.d_out_wb;
      SRC_IMM: w_sel_data = wb.offset_wb;
      SRC_ALU: w_sel_data = wb.alu_result_wb;
      default: w_sel_data = '0;
    endcase
  end

  // sw never selects a source, so it can never write.
  assign w_wen = wb.wre_wb && (w_src != SRC_NONE) && (wb.rt_wb != '0);

  // Echo stays live during reset so forwarding sees the same view.
  assign wb.wb_valid = w_wen;
  assign wb.wb_addr  = wb.rt_wb;
  assign wb.wb_data  = w_wen ? w_sel_data : '0;

  regfile_8x64 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wen && !rst),
    .i_waddr   (wb.rt_wb),
    .i_wdata   (w_sel_data),
    .i_raddr_a (rd_addr_a),
    .i_raddr_b (rd_addr_b),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

`ifdef WB_BYPASS_EN
  // w_wen already excludes r0, so a bypass hit never returns nonzero for r0.
  assign rd_data_a = (w_wen && (rd_addr_a == wb.rt_wb)) ? w_sel_data : w_rd_a;
  assign rd_data_b = (w_wen && (rd_addr_b == wb.rt_wb)) ? w_sel_data : w_rd_b;
`else
  assign rd_data_a = w_rd_a;
  assign rd_data_b = w_rd_b;
`endif

  assign w_ops    = {wb.addi_wb, wb.movi_wb, wb.lw_wb, wb.sw_wb, wb.subi_wb};
  assign w_retire = |w_ops;
  assign w_multi  = multi_flag(w_ops);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_retire && (r_retire_cnt != '1)) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_err <= 1'b0;
    end else if (w_multi) begin
      r_flag_err <= 1'b1;
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign flag_err   = r_flag_err;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Self-checking bench for wb_regfile: directed scenarios followed by
// randomized M/WB words, compared against an array-based reference model.
// Honours WB_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_wb_regfile;
  import wb_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic [31:0] retire_cnt;
  logic        flag_err;

  wb_regfile_if wbif ();

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wbif),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .retire_cnt (retire_cnt),
    .flag_err   (flag_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference state
  logic [63:0] m_reg [8];
  logic [31:0] m_cnt;
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mread(input bit [2:0] a, input bit ev,
                                        input bit [2:0] rt, input logic [63:0] d);
    if (a == 3'd0) return 64'd0;
    if (BYP && ev && (a == rt)) return d;
    return m_reg[a];
  endfunction

  // f = {noop, addi, movi, lw, sw, subi}
  task automatic apply(input bit r, input bit [5:0] f, input bit we, input bit [2:0] rt,
                       input logic [63:0] dout, input logic [63:0] alu, input logic [63:0] off,
                       input bit [2:0] ra, input bit [2:0] rb);
    logic [63:0] d;
    bit has, ev, retire;
    int nops;
    @(negedge clk);
    rst                = r;
    wbif.noop_wb       = f[5];
    wbif.addi_wb       = f[4];
    wbif.movi_wb       = f[3];
    wbif.lw_wb         = f[2];
    wbif.sw_wb         = f[1];
    wbif.subi_wb       = f[0];
    wbif.wre_wb        = we;
    wbif.rt_wb         = rt;
    wbif.d_out_wb      = dout;
    wbif.alu_result_wb = alu;
    wbif.offset_wb     = off;
    rd_addr_a          = ra;
    rd_addr_b          = rb;

    d = 64'd0;
    if (f[2])             d = dout;
    else if (f[3])        d = off;
    else if (f[4] | f[0]) d = alu;
    has    = f[2] | f[3] | f[4] | f[0];
    ev     = we && has && (rt != 3'd0);
    retire = |f[4:0];
    nops   = 0;
    for (int i = 0; i < 5; i++) if (f[i]) nops++;

    #1;
    check("wb_valid", 64'(wbif.wb_valid), 64'(ev));
    check("wb_addr",  64'(wbif.wb_addr),  64'(rt));
    check("wb_data",  wbif.wb_data, ev ? d : 64'd0);
    check("pre_rd_a", rd_data_a, mread(ra, ev, rt, d));
    check("pre_rd_b", rd_data_b, mread(rb, ev, rt, d));

    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 64'd0;
      m_cnt = 32'd0;
      m_err = 1'b0;
    end else begin
      if (ev) m_reg[rt] = d;
      if (retire && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
      if (nops >= 2) m_err = 1'b1;
    end
    #1;
    check("post_rd_a",  rd_data_a, mread(ra, ev, rt, d));
    check("post_rd_b",  rd_data_b, mread(rb, ev, rt, d));
    check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
    check("flag_err",   64'(flag_err), 64'(m_err));
  endtask

  task automatic idle(input bit [2:0] ra, input bit [2:0] rb);
    apply(1'b0, 6'b000000, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, ra, rb);
  endtask

  initial begin
    bit [5:0] f;
    for (int i = 0; i < 8; i++) m_reg[i] = 64'd0;
    m_cnt = 32'd0;
    m_err = 1'b0;
    rst = 1'b1;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    wbif.noop_wb = 0; wbif.addi_wb = 0; wbif.movi_wb = 0; wbif.lw_wb = 0;
    wbif.sw_wb = 0; wbif.subi_wb = 0; wbif.wre_wb = 0; wbif.rt_wb = 0;
    wbif.d_out_wb = 0; wbif.alu_result_wb = 0; wbif.offset_wb = 0;
    repeat (2) @(posedge clk);

    // reset state: every register, counter and error flag at zero
    for (int i = 0; i < 8; i += 2) idle(3'(i), 3'(i + 1));

    // load into r3
    apply(0, 6'b000100, 1, 3'd3, 64'hDEAD_BEEF, 64'd0, 64'd0, 3'd3, 3'd0);
    // movi to r0 is discarded but retires
    apply(0, 6'b001000, 1, 3'd0, 64'd0, 64'd0, 64'd5, 3'd0, 3'd3);
    // r2 = 1, then addi r2 = 7 read through port B before and after the edge
    apply(0, 6'b001000, 1, 3'd2, 64'd0, 64'd0, 64'd1, 3'd3, 3'd2);
    apply(0, 6'b010000, 1, 3'd2, 64'd0, 64'd7, 64'd0, 3'd0, 3'd2);
    idle(3'd2, 3'd2);
    // wre low blocks the write but the instruction still retires
    apply(0, 6'b010000, 0, 3'd2, 64'd0, 64'd99, 64'd0, 3'd2, 3'd0);
    // noop with subi: subi governs
    apply(0, 6'b100001, 1, 3'd5, 64'd0, 64'h1234, 64'd0, 3'd5, 3'd5);
    // noop alone and sw never write
    apply(0, 6'b100000, 1, 3'd5, 64'd1, 64'd1, 64'd1, 3'd5, 3'd0);
    apply(0, 6'b000010, 1, 3'd5, 64'd2, 64'd2, 64'd2, 3'd5, 3'd0);
    // lw + addi: load wins, error becomes sticky
    apply(0, 6'b010100, 1, 3'd4, 64'd9, 64'd11, 64'd0, 3'd4, 3'd4);
    idle(3'd4, 3'd1);
    // movi + subi + addi: immediate wins
    apply(0, 6'b011001, 1, 3'd7, 64'd0, 64'hAA, 64'h77, 3'd7, 3'd6);

    // counter saturation: preload near the top
    @(negedge clk);
    force dut.r_retire_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_retire_cnt;
    m_cnt = 32'hFFFF_FFFE;
    apply(0, 6'b000010, 1, 3'd1, 64'd3, 64'd3, 64'd3, 3'd1, 3'd2);
    apply(0, 6'b000010, 1, 3'd6, 64'd4, 64'd4, 64'd4, 3'd3, 3'd4);
    apply(0, 6'b000010, 1, 3'd7, 64'd5, 64'd5, 64'd5, 3'd5, 3'd6);
    idle(3'd7, 3'd1);

    // reset wins over a simultaneous write into a live register
    apply(0, 6'b001000, 1, 3'd6, 64'd0, 64'd0, 64'h55, 3'd6, 3'd0);
    apply(1, 6'b010000, 1, 3'd6, 64'd0, 64'h10, 64'd0, 3'd6, 3'd6);
    idle(3'd6, 3'd4);

    // randomized M/WB words
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) f = 6'(1 << $urandom_range(0, 5));
      else                          f = 6'($urandom);
      apply($urandom_range(0, 49) == 0, f, 1'($urandom), 3'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have clk, input, 1, pipeline clock, all state updated on rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have noop_wb, addi_wb, movi_wb, lw_wb, sw_wb, subi_wb, input, 1 each, opcode flags from the M/WB register.
REQ-004 SHALL have wre_wb, input, 1, write-enable from the M/WB register.
REQ-005 SHALL have d_out_wb, alu_result_wb, offset_wb, input, 64 each, memory load data, ALU result, sign-extended immediate.
REQ-006 SHALL have rt_wb, input, 3, destination register index.
REQ-007 SHALL have rd_addr_a, rd_addr_b, input, 3 each, decode-stage read indices.
REQ-008 SHALL have rd_data_a, rd_data_b, output, 64 each, read data.
REQ-009 SHALL have wb_valid (1), wb_addr (3), wb_data (64), outputs, current-cycle write echo for forwarding.
REQ-010 SHALL have retire_cnt, output, 32, retired-instruction count.
REQ-011 SHALL have flag_err, output, 1, sticky multi-flag error.

Function
REQ-012 Write source SHALL be: lw_wb -> d_out_wb; movi_wb -> offset_wb; addi_wb or subi_wb -> alu_result_wb.
REQ-013 Priority when several flags are set SHALL be lw > movi > addi > subi.
REQ-014 Write enable SHALL be wre_wb AND (lw|movi|addi|subi) AND rt_wb != 0.
REQ-015 sw_wb and noop_wb SHALL never write the register file.
REQ-016 Register 0 SHALL always read 0; writes to it SHALL be discarded and SHALL deassert wb_valid.
REQ-017 Writes SHALL commit on the rising clk edge; latency from flags to stored value is one edge.
REQ-018 Reads SHALL be combinational from rd_addr_a/b; both ports SHALL be independent and may address the same register.
REQ-019 wb_valid/wb_addr/wb_data SHALL be combinational and equal write enable, rt_wb, and the selected data; wb_data SHALL be 0 when wb_valid=0.
REQ-020 retire_cnt SHALL increment by 1 on each edge where any of addi/movi/lw/sw/subi is set, regardless of wre_wb.
REQ-021 retire_cnt SHALL saturate at 0xFFFFFFFF.
REQ-022 flag_err SHALL set on any edge where two or more of addi/movi/lw/sw/subi are set, and hold until reset.
REQ-023 noop_wb with any other flag set SHALL be ignored (other flags govern).

Reset
REQ-024 rst SHALL clear all 8 registers, retire_cnt and flag_err to 0 on the next edge.
REQ-025 rst SHALL take priority over a simultaneous write, counter increment and error set.
REQ-026 wb_valid/wb_addr/wb_data SHALL remain combinational during reset; the write itself SHALL be suppressed.

Configuration
REQ-027 With WB_BYPASS_EN defined, a read whose address equals wb_addr while wb_valid=1 SHALL return wb_data in the same cycle.
REQ-028 Without WB_BYPASS_EN, such reads SHALL return the pre-write stored value; the new value SHALL be visible after the edge.

Structure
REQ-029 Package wb_pkg SHALL hold NUM_REGS=8, ADDR_W=3, DATA_W=64, CNT_W=32 and the write-source enum (SRC_NONE, SRC_MEM, SRC_IMM, SRC_ALU).
REQ-030 Storage SHALL be one sub-module regfile_8x64 (1 write port, 2 async read ports, r0 hardwired 0); source selection, bypass, counter and error logic SHALL be in wb_regfile.

Verification
REQ-031 lw_wb=1, wre_wb=1, rt_wb=3, d_out_wb=0xDEAD_BEEF -> after edge rd_addr_a=3 gives 0xDEADBEEF; retire_cnt=1.
REQ-032 movi_wb=1, wre_wb=1, rt_wb=0, offset_wb=5 -> wb_valid=0, rd_data_a(0)=0, retire_cnt increments.
REQ-033 addi_wb=1, wre_wb=1, rt_wb=2, alu_result_wb=7, rd_addr_b=2, old r2=1 -> pre-edge rd_data_b=7 with WB_BYPASS_EN, 1 without; 7 after edge both builds.
REQ-034 lw_wb=addi_wb=1, wre_wb=1, rt_wb=4, d_out_wb=9, alu_result_wb=11 -> r4=9, flag_err=1 and stays 1 until rst.
REQ-035 retire_cnt preloaded to 0xFFFFFFFE via 2^32-2 sw_wb cycles (or force) -> two more sw_wb cycles give 0xFFFFFFFF; r1..r7 unchanged.
REQ-036 rst=1 with addi_wb=1, wre_wb=1, rt_wb=6, alu_result_wb=0x10 -> after edge r6=0, retire_cnt=0, flag_err=0.
